// File: rtl/wf68k30l_multiplier.sv
// Sequential shift-add multiplier for MULS/MULU (16x16->32, 32x32->32, 32x32->64).
// Shares the ALU start handshake (ALU_INIT + OP_IN) and one-cycle ready pulse with the divider.

package wf68k30l_mul_pkg;
    localparam int unsigned OP_W = 7;
    localparam int unsigned SZ_W = 2;

    localparam logic [OP_W-1:0] MULS = 7'h2A;
    localparam logic [OP_W-1:0] MULU = 7'h2B;

    localparam logic [SZ_W-1:0] BYTE = 2'b00;
    localparam logic [SZ_W-1:0] WORD = 2'b01;
    localparam logic [SZ_W-1:0] LONG = 2'b10;
endpackage

module wf68k30l_multiplier
    import wf68k30l_mul_pkg::*;
(
    input  logic            CLK,
    input  logic            RESETn,
    input  logic [OP_W-1:0] OP_IN,
    input  logic [OP_W-1:0] OP,
    input  logic [SZ_W-1:0] OP_SIZE,
    input  logic            ALU_INIT,
    input  logic [15:0]     BIW_1,
    input  logic [31:0]     OP1,
    input  logic [31:0]     OP2,
    output logic [31:0]     PRODUCT_LO,
    output logic [31:0]     PRODUCT_HI,
    output logic            VFLAG_MUL,
    output logic            MUL_RDY
);
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 64;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_INIT,
        MUL_CALC
    } state_t;

    state_t          state,     state_nxt;
    logic [AW-1:0]   acc,       acc_nxt;
    logic [DW-1:0]   mcand,     mcand_nxt;
    logic [DW-1:0]   mplier,    mplier_nxt;
    logic [CW-1:0]   bitcnt,    bitcnt_nxt;
    logic            sign,      sign_nxt;
    logic            is_long,   is_long_nxt;
    logic            is_signed, is_signed_nxt;
    logic            mode64,    mode64_nxt;
    logic [DW-1:0]   prod_lo,   prod_lo_nxt;
    logic [DW-1:0]   prod_hi,   prod_hi_nxt;
    logic            vflag,     vflag_nxt;
    logic            rdy,       rdy_nxt;

    // Operand conditioning for MUL_INIT: sign extraction and magnitude.
    logic          long_in;
    logic          signed_in;
    logic          neg1;
    logic          neg2;
    logic [DW-1:0] mag1;
    logic [DW-1:0] mag2;

    assign long_in   = (OP_SIZE == LONG);
    assign signed_in = (OP == MULS);
    assign neg1      = signed_in && (long_in ? OP1[31] : OP1[15]);
    assign neg2      = signed_in && (long_in ? OP2[31] : OP2[15]);

    assign mag1 = long_in ? (neg1 ? DW'(-OP1) : OP1)
                          : {16'h0000, (neg1 ? 16'(-OP1[15:0]) : OP1[15:0])};
    assign mag2 = long_in ? (neg2 ? DW'(-OP2) : OP2)
                          : {16'h0000, (neg2 ? 16'(-OP2[15:0]) : OP2[15:0])};

    // One partial product per cycle; the final cycle folds in the sign.
    logic [AW-1:0] partial;
    logic [AW-1:0] sum;
    logic [AW-1:0] result;
    logic          last;
    logic          ovf;

    assign partial = mplier[bitcnt] ? (AW'(mcand) << bitcnt) : '0;
    assign sum     = acc + partial;
    assign result  = sign ? AW'(-sum) : sum;
    assign last    = (bitcnt == (is_long ? CW'(31) : CW'(15)));
    assign ovf     = is_signed ? (result[63:32] != {DW{result[31]}})
                               : (result[63:32] != '0);

    logic unused_biw;
    assign unused_biw = ^{BIW_1[15:11], BIW_1[9:0]};

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state     <= MUL_IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            bitcnt    <= '0;
            sign      <= 1'b0;
            is_long   <= 1'b0;
            is_signed <= 1'b0;
            mode64    <= 1'b0;
            prod_lo   <= '0;
            prod_hi   <= '0;
            vflag     <= 1'b0;
            rdy       <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            mcand     <= mcand_nxt;
            mplier    <= mplier_nxt;
            bitcnt    <= bitcnt_nxt;
            sign      <= sign_nxt;
            is_long   <= is_long_nxt;
            is_signed <= is_signed_nxt;
            mode64    <= mode64_nxt;
            prod_lo   <= prod_lo_nxt;
            prod_hi   <= prod_hi_nxt;
            vflag     <= vflag_nxt;
            rdy       <= rdy_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        mcand_nxt     = mcand;
        mplier_nxt    = mplier;
        bitcnt_nxt    = bitcnt;
        sign_nxt      = sign;
        is_long_nxt   = is_long;
        is_signed_nxt = is_signed;
        mode64_nxt    = mode64;
        prod_lo_nxt   = prod_lo;
        prod_hi_nxt   = prod_hi;
        vflag_nxt     = vflag;
        rdy_nxt       = 1'b0;

        case (state)
            MUL_IDLE: begin
                if (ALU_INIT && (OP_IN == MULS || OP_IN == MULU)) begin
                    state_nxt = MUL_INIT;
                end
            end

            MUL_INIT: begin
                mcand_nxt     = mag2;
                mplier_nxt    = mag1;
                sign_nxt      = neg1 ^ neg2;
                is_long_nxt   = long_in;
                is_signed_nxt = signed_in;
                mode64_nxt    = long_in && BIW_1[10];
                acc_nxt       = '0;
                bitcnt_nxt    = '0;
                vflag_nxt     = 1'b0;
                if (mag1 == '0 || mag2 == '0) begin
                    prod_lo_nxt = '0;
                    prod_hi_nxt = '0;
                    rdy_nxt     = 1'b1;
                    state_nxt   = MUL_IDLE;
                end else begin
                    state_nxt = MUL_CALC;
                end
            end

            MUL_CALC: begin
                acc_nxt    = sum;
                bitcnt_nxt = CW'(bitcnt + CW'(1));
                if (last) begin
                    prod_lo_nxt = result[31:0];
                    if (is_long) begin
                        prod_hi_nxt = result[63:32];
                    end else begin
                        prod_hi_nxt = is_signed ? {DW{result[31]}} : '0;
                    end
                    vflag_nxt = is_long && !mode64 && ovf;
                    rdy_nxt   = 1'b1;
                    state_nxt = MUL_IDLE;
                end
            end

            default: state_nxt = MUL_IDLE;
        endcase
    end

    assign PRODUCT_LO = prod_lo;
    assign PRODUCT_HI = prod_hi;
    assign VFLAG_MUL  = vflag;
    assign MUL_RDY    = rdy;

endmodule

// File: tb/tb_wf68k30l_multiplier.sv
// Scoreboard bench for wf68k30l_multiplier: directed cases plus randomized MULS/MULU traffic
// checked against a plain-arithmetic reference model.

module tb_wf68k30l_multiplier;
    import wf68k30l_mul_pkg::*;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic [6:0]  OP_IN;
    logic [6:0]  OP;
    logic [1:0]  OP_SIZE;
    logic        ALU_INIT;
    logic [15:0] BIW_1;
    logic [31:0] OP1;
    logic [31:0] OP2;
    logic [31:0] PRODUCT_LO;
    logic [31:0] PRODUCT_HI;
    logic        VFLAG_MUL;
    logic        MUL_RDY;

    wf68k30l_multiplier dut (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .OP_IN      (OP_IN),
        .OP         (OP),
        .OP_SIZE    (OP_SIZE),
        .ALU_INIT   (ALU_INIT),
        .BIW_1      (BIW_1),
        .OP1        (OP1),
        .OP2        (OP2),
        .PRODUCT_LO (PRODUCT_LO),
        .PRODUCT_HI (PRODUCT_HI),
        .VFLAG_MUL  (VFLAG_MUL),
        .MUL_RDY    (MUL_RDY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        v;
        longint      lat;
        longint      t0;
    } exp_t;

    exp_t   sb[$];
    longint cyc = 0;
    int     n_vec = 0;
    int     n_err = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: signed or unsigned product of the sized operands, plain 64-bit arithmetic.
    function automatic exp_t model(input logic [6:0] op, input logic [1:0] sz, input logic b10,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa;
        longint      sb_;
        int          ia;
        int          ib;
        shortint     wa;
        shortint     wb;
        logic [63:0] r;
        bit          lng;
        bit          sgn;
        lng = (sz == LONG);
        sgn = (op == MULS);
        if (lng) begin
            ia = a; ib = b;
            sa  = sgn ? longint'(ia) : longint'({32'h0, a});
            sb_ = sgn ? longint'(ib) : longint'({32'h0, b});
        end else begin
            wa = a[15:0]; wb = b[15:0];
            sa  = sgn ? longint'(wa) : longint'({48'h0, a[15:0]});
            sb_ = sgn ? longint'(wb) : longint'({48'h0, b[15:0]});
        end
        r    = 64'(sa * sb_);
        e.lo = r[31:0];
        if (lng) e.hi = r[63:32];
        else     e.hi = sgn ? {32{r[31]}} : 32'h0;
        e.v  = lng && !b10 && (sgn ? (r[63:32] != {32{r[31]}}) : (r[63:32] != 32'h0));
        e.lat = (sa == 0 || sb_ == 0) ? 2 : (lng ? 34 : 18);
        e.t0 = 0;
        return e;
    endfunction

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (RESETn === 1'b1 && MUL_RDY === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_rdy: got MUL_RDY=1 expected 0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("product_lo", 64'(PRODUCT_LO), 64'(e.lo));
                chk("product_hi", 64'(PRODUCT_HI), 64'(e.hi));
                chk("vflag",      64'(VFLAG_MUL),  64'(e.v));
                chk("latency",    64'(cyc - e.t0), 64'(e.lat));
            end
        end
    end

    task automatic issue(input logic [6:0] op, input logic [1:0] sz, input logic b10,
                         input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge CLK);
        OP_IN    = op;
        OP       = op;
        OP_SIZE  = sz;
        BIW_1    = 16'($urandom);
        BIW_1[10] = b10;
        OP1      = a;
        OP2      = b;
        ALU_INIT = 1'b1;
        e    = model(op, sz, b10, a, b);
        e.t0 = cyc;
        sb.push_back(e);
        @(negedge CLK);
        ALU_INIT = 1'b0;
        OP_IN    = 7'($urandom);
        @(negedge CLK);
        OP1     = $urandom;
        OP2     = $urandom;
        OP      = 7'($urandom);
        OP_SIZE = 2'($urandom);
        BIW_1   = 16'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            @(negedge CLK);
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: got %0d outstanding results expected 0", sb.size());
            sb.delete();
        end
        @(negedge CLK);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_8000;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        RESETn   = 1'b0;
        OP_IN    = '0;
        OP       = '0;
        OP_SIZE  = WORD;
        ALU_INIT = 1'b0;
        BIW_1    = '0;
        OP1      = '0;
        OP2      = '0;
        repeat (3) @(negedge CLK);
        chk("reset_lo",  64'(PRODUCT_LO), 64'h0);
        chk("reset_hi",  64'(PRODUCT_HI), 64'h0);
        chk("reset_v",   64'(VFLAG_MUL),  64'h0);
        chk("reset_rdy", 64'(MUL_RDY),    64'h0);
        RESETn = 1'b1;
        repeat (2) @(negedge CLK);

        issue(MULU, WORD, 1'b0, 32'h0000_FFFF, 32'h1234_FFFF); wait_done();
        issue(MULS, WORD, 1'b0, 32'h0000_FFFE, 32'h0000_0003); wait_done();
        issue(MULU, LONG, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done();
        issue(MULS, LONG, 1'b0, 32'h8000_0000, 32'h0000_0001); wait_done();
        issue(MULS, LONG, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF); wait_done();
        issue(MULS, LONG, 1'b0, 32'h0001_0000, 32'h0001_0000); wait_done();
        issue(MULS, WORD, 1'b0, 32'h0000_8000, 32'h0000_8000); wait_done();
        issue(MULU, LONG, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF); wait_done();

        // Non-multiply opcode with the strobe must not start anything.
        @(negedge CLK);
        OP_IN    = 7'h10;
        ALU_INIT = 1'b1;
        @(negedge CLK);
        ALU_INIT = 1'b0;
        repeat (40) @(negedge CLK);

        // A strobe during CALC is ignored: exactly one pulse.
        issue(MULU, LONG, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (5) @(negedge CLK);
        OP_IN    = MULU;
        ALU_INIT = 1'b1;
        @(negedge CLK);
        ALU_INIT = 1'b0;
        wait_done();
        repeat (40) @(negedge CLK);

        // Reset in the middle of a long operation aborts it.
        issue(MULS, LONG, 1'b1, 32'h7654_3210, 32'hFEDC_BA98);
        repeat (10) @(negedge CLK);
        RESETn = 1'b0;
        sb.delete();
        #1;
        chk("abort_lo",  64'(PRODUCT_LO), 64'h0);
        chk("abort_hi",  64'(PRODUCT_HI), 64'h0);
        chk("abort_v",   64'(VFLAG_MUL),  64'h0);
        chk("abort_rdy", 64'(MUL_RDY),    64'h0);
        repeat (3) @(negedge CLK);
        RESETn = 1'b1;
        repeat (40) @(negedge CLK);
        issue(MULU, WORD, 1'b0, 32'h0000_0003, 32'h0000_0005); wait_done();

        for (int n = 0; n < 150; n++) begin
            logic [6:0] op;
            logic [1:0] sz;
            op = ($urandom_range(0, 1) == 0) ? MULS : MULU;
            sz = ($urandom_range(0, 1) == 0) ? WORD : LONG;
            issue(op, sz, 1'($urandom), pick(), pick());
            wait_done();
        end

        repeat (5) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wf68k30l_multiplier.md
Name: wf68k30l_multiplier

Overview:
- Sequential shift-add multiplier for MULS/MULU: 16x16->32, 32x32->32 and 32x32->64.
- Sits in the ALU beside the division state machine and uses the same ALU_INIT / OP_IN start handshake and the same one-cycle ready pulse.
- Produces a 64-bit product split into low and high longwords, plus the overflow flag for the 32-bit long result.

Parameters:
- None. Operation and size codes (MULS, MULU, WORD, LONG) come from the shared op package.

Ports:
- CLK  in  1  clock, rising edge.
- RESETn  in  1  reset, asynchronous, active-low.
- OP_IN  in  7  incoming operation code; sampled with ALU_INIT in idle.
- OP  in  7  current operation; sampled in MUL_INIT.
- OP_SIZE  in  2  WORD or LONG; sampled in MUL_INIT.
- ALU_INIT  in  1  start strobe.
- BIW_1  in  16  bit 10 = 64-bit product select (long only).
- OP1  in  32  source operand (multiplier).
- OP2  in  32  destination operand (multiplicand).
- PRODUCT_LO  out  32  product bits 31:0.
- PRODUCT_HI  out  32  product bits 63:32.
- VFLAG_MUL  out  1  overflow flag.
- MUL_RDY  out  1  one-cycle result-valid pulse.

Behaviour:
- Reset (RESETn=0, asynchronous): state MUL_IDLE; PRODUCT_LO, PRODUCT_HI, VFLAG_MUL and MUL_RDY are all 0. Reset mid-operation aborts the operation with no MUL_RDY pulse.
- MUL_RDY defaults to 0 every cycle. It is high for exactly one cycle per accepted operation.
- MUL_IDLE:
  - ALU_INIT=1 with OP_IN in {MULS, MULU} -> MUL_INIT.
  - Any other OP_IN, or ALU_INIT=0: stay in MUL_IDLE.
- MUL_INIT: latch all operands, so inputs may change after this cycle.
  - WORD: operands are OP1[15:0] and OP2[15:0]. Iteration count N=16.
  - LONG: operands are the full 32 bits. N=32.
  - MULS: take the absolute value of each operand and latch result sign = sign(OP1) XOR sign(OP2), using bit 15 for WORD and bit 31 for LONG. MULU: use operands unchanged, sign=0.
  - Latch MODE64 = (OP_SIZE==LONG && BIW_1[10]).
  - Clear the accumulator and VFLAG_MUL.
  - If either magnitude is 0: PRODUCT_LO=0, PRODUCT_HI=0, VFLAG_MUL=0, MUL_RDY=1, next state MUL_IDLE.
  - Otherwise: next state MUL_CALC with BITCNT=0.
- MUL_CALC: one multiplier bit per cycle, LSB first.
  - If multiplier[BITCNT]=1: add (multiplicand << BITCNT) into the 64-bit accumulator.
  - Increment BITCNT.
  - The last cycle is BITCNT==N-1. In that cycle, compute the final value (accumulator plus last partial product), then negate it (64-bit two's complement) if sign=1.
  - WORD: PRODUCT_LO = result[31:0]; PRODUCT_HI = sign extension of result[31] for MULS, 0 for MULU; VFLAG_MUL=0.
  - LONG with MODE64=1: PRODUCT_LO = result[31:0], PRODUCT_HI = result[63:32], VFLAG_MUL=0.
  - LONG with MODE64=0: PRODUCT_LO = result[31:0], PRODUCT_HI = result[63:32], and VFLAG_MUL=1 if:
    - MULU: result[63:32] != 0;
    - MULS: result[63:32] is not all copies of result[31].
  - In the same cycle: MUL_RDY=1, next state MUL_IDLE.
- Latency, counted in rising edges after the edge that samples ALU_INIT:
  - zero operand: 2;
  - WORD: 18;
  - LONG: 34.
- ALU_INIT while in MUL_INIT or MUL_CALC is ignored; no queuing.
- Outputs hold their last value until the next completion or reset.
- Accumulator arithmetic is 64-bit unsigned. The magnitude of -2^31 is 2^31, which is representable; -2^15 likewise for WORD.

Test Plan:
- MULU.W OP1=$0000FFFF, OP2=$1234FFFF -> PRODUCT_LO=$FFFE0001, PRODUCT_HI=0, VFLAG_MUL=0, MUL_RDY exactly 18 edges after ALU_INIT.
- MULS.W OP1=$FFFE (-2), OP2=$0003 -> PRODUCT_LO=$FFFFFFFA, PRODUCT_HI=$FFFFFFFF, VFLAG_MUL=0.
- MULU.L with BIW_1[10]=1, OP1=OP2=$FFFFFFFF -> PRODUCT_HI=$FFFFFFFE, PRODUCT_LO=$00000001, VFLAG_MUL=0, RDY at 34 edges.
- MULS.L with BIW_1[10]=0:
  - $80000000 x $00000001 -> PRODUCT_LO=$80000000, VFLAG_MUL=0;
  - $80000000 x $FFFFFFFF -> PRODUCT_LO=$80000000, PRODUCT_HI=0, VFLAG_MUL=1;
  - $00010000 x $00010000 -> VFLAG_MUL=1.
- MULU.L with OP1=0, OP2=$DEADBEEF -> both products 0, MUL_RDY 2 edges after ALU_INIT. Then re-issue ALU_INIT mid-CALC of a LONG operation -> ignored; exactly one MUL_RDY pulse.
- Assert RESETn=0 at CALC cycle 10 of a LONG operation -> outputs 0 immediately, state idle, no MUL_RDY. After release, a new MULU.W 3x5 gives PRODUCT_LO=$0000000F.
